// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: splits a transfer into 2*DATA_W+2 units of CLK_DIV cycles
// (lead, 2*DATA_W half-periods, trail) and toggles sclk entering each half-period.
module spi_clk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  localparam int UNIT_W = $clog2(2*DATA_W+2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              active,
  input  logic              cpol,
  output logic              sclk,
  output logic              tick,
  output logic              lead_next,
  output logic              trail_next,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic [UNIT_W-1:0] hp_cnt
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             toggle;

  // *_next fire on the clk edge that moves sclk; *_edge are high in the cycle after it
  assign tick       = active && (div_cnt == DIV_W'(CLK_DIV-1));
  assign toggle     = tick && (hp_cnt < UNIT_W'(2*DATA_W));
  assign lead_next  = toggle && !hp_cnt[0];
  assign trail_next = toggle && hp_cnt[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      hp_cnt     <= '0;
      sclk       <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
    end else begin
      lead_edge  <= lead_next;
      trail_edge <= trail_next;
      if (load) begin
        div_cnt <= '0;
        hp_cnt  <= '0;
        sclk    <= cpol;
      end else if (tick) begin
        div_cnt <= '0;
        hp_cnt  <= hp_cnt + 1'b1;
        if (toggle) sclk <= ~sclk;
      end else if (active) begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: per-transfer CPOL/CPHA and bit order, start/busy/done
// handshake with back-to-back support, and an error flag for out-of-range sel.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV    = 2,
  localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  lsb_first,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_W-1:0]     tx_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_SLAVES-1:0] ss_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     rx_data
);
  localparam int UNIT_W = $clog2(2*DATA_W+2);
  localparam logic [UNIT_W-1:0] LAST_HP    = UNIT_W'(2*DATA_W);
  localparam logic [UNIT_W-1:0] LAST_TRAIL = UNIT_W'(2*DATA_W-1);

  spi_state_t          state;
  logic                cpha, lsb, sel_ok_q;
  logic [DATA_W-1:0]   tx_sh, rx_sh;
  logic                accept, active, sel_ok, adv, sample;
  logic                tick, lead_next, trail_next, lead_edge, trail_edge;
  logic [UNIT_W-1:0]   hp_cnt;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsbf);
    return lsbf ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsbf);
    return lsbf ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsbf,
                                                 input logic b);
    return lsbf ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign accept = (state == IDLE) && start;
  assign active = (state != IDLE);
  assign sel_ok = (32'(sel) < NUM_SLAVES);
  // CPHA=0 preloads bit 0 at accept, so its final trailing edge carries no new bit
  assign adv    = active && (cpha ? lead_next : (trail_next && hp_cnt != LAST_TRAIL));
  assign sample = active && (cpha ? trail_edge : lead_edge);

  spi_clk_gen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .active     (active),
    .cpol       (mode[CPOL_BIT]),
    .sclk       (sclk),
    .tick       (tick),
    .lead_next  (lead_next),
    .trail_next (trail_next),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .hp_cnt     (hp_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cpha     <= 1'b0;
      lsb      <= 1'b0;
      sel_ok_q <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rx_data  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (adv) mosi <= first_bit(tx_sh, lsb);
      case (state)
        IDLE: if (start) begin
          state    <= LEAD;
          cpha     <= mode[CPHA_BIT];
          lsb      <= lsb_first;
          sel_ok_q <= sel_ok;
          busy     <= 1'b1;
          ss_n     <= sel_ok ? ~(NUM_SLAVES'(1) << sel) : '1;
          if (!mode[CPHA_BIT]) mosi <= first_bit(tx_data, lsb_first);
        end
        LEAD: if (tick) state <= XFER;
        XFER: if (tick && hp_cnt == LAST_HP) state <= TRAIL;
        TRAIL: if (tick) begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          err     <= !sel_ok_q;
          ss_n    <= '1;
          rx_data <= rx_sh;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers carry data only; every transfer fully rewrites them
  always_ff @(posedge clk) begin
    if (accept) tx_sh <= mode[CPHA_BIT] ? tx_data : shift_out(tx_data, lsb_first);
    else if (adv) tx_sh <= shift_out(tx_sh, lsb);
    if (sample) rx_sh <= shift_in(rx_sh, lsb, miso);
  end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a protocol-level SPI slave model plus loopback runs.
module tb_spi_master_param;
  logic clk = 1'b0;
  logic reset;
  logic start, lsb_first, miso, sclk, mosi, busy, done, err;
  logic [1:0] mode, sel;
  logic [7:0] tx_data, rx_data;
  logic [2:0] ss_n;

  logic start_w, lsb_w, sclk_w, mosi_w, busy_w, done_w, err_w;
  logic [1:0] mode_w, sel_w;
  logic [15:0] tx_w, rx_w;
  logic [2:0] ss_w;

  logic loop_en = 1'b0;
  logic slv_miso = 1'b0;
  logic [1:0] cur_mode = '0;
  logic cur_lsb = 1'b0;
  logic [1:0] cur_sel = '0;
  logic [7:0] cur_tx = '0, slv_word = '0;

  logic sclk_q = 1'b0, busy_q = 1'b0, lead = 1'b0;
  int s_idx = 0, n_edges = 0;
  bit sq[$];

  int n_tests = 0, n_fail = 0;

  assign miso = loop_en ? mosi : slv_miso;
  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_SLAVES(3), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .lsb_first(lsb_first),
    .sel(sel), .tx_data(tx_data), .miso(miso), .sclk(sclk), .mosi(mosi),
    .ss_n(ss_n), .busy(busy), .done(done), .err(err), .rx_data(rx_data));

  spi_master_param #(.DATA_W(16), .NUM_SLAVES(3), .CLK_DIV(1)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .mode(mode_w), .lsb_first(lsb_w),
    .sel(sel_w), .tx_data(tx_w), .miso(mosi_w), .sclk(sclk_w), .mosi(mosi_w),
    .ss_n(ss_w), .busy(busy_w), .done(done_w), .err(err_w), .rx_data(rx_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sbit(input int i);
    return cur_lsb ? slv_word[3'(i)] : slv_word[3'(7 - i)];
  endfunction

  // Slave: samples mosi on its capture edge, presents the next miso bit on the other edge
  always @(negedge clk) begin
    if (busy && !busy_q) begin
      sq.delete();
      n_edges = 0;
      if (!cur_mode[0]) begin
        slv_miso = sbit(0);
        s_idx = 1;
      end else s_idx = 0;
    end else if (busy && busy_q && sclk !== sclk_q) begin
      n_edges++;
      lead = (sclk != cur_mode[1]);
      if (lead != cur_mode[0]) sq.push_back(mosi);
      else if (s_idx < 8) begin
        slv_miso = sbit(s_idx);
        s_idx++;
      end
    end
    sclk_q = sclk;
    busy_q = busy;
  end

  task automatic launch(input logic [1:0] m, input logic l, input logic [1:0] s,
                        input logic [7:0] tx, input logic [7:0] sw, input bit keep);
    @(negedge clk);
    cur_mode = m; cur_lsb = l; cur_sel = s; cur_tx = tx; slv_word = sw;
    mode = m; lsb_first = l; sel = s; tx_data = tx; start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
  endtask

  task automatic wait_done(input int poke);
    int bad;
    bit seen;
    logic [2:0] ess;
    logic [7:0] sw_got;
    ess = (cur_sel < 3) ? ~(3'b001 << cur_sel) : 3'b111;
    bad = 0;
    seen = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      if (poke != 0 && n == poke) start = 1'b1;
      if (poke != 0 && n == poke + 1) start = 1'b0;
      if (done) begin
        seen = 1;
        check("latency", n, 37);
        check("ss_during_xfer", bad, 0);
        check("ss_at_done", ss_n, 3'b111);
        check("busy_at_done", busy, 1'b0);
        check("err", err, cur_sel >= 2'd3);
        check("rx_data", rx_data, loop_en ? cur_tx : slv_word);
        check("sclk_edges", n_edges, 16);
        check("sclk_at_done", sclk, cur_mode[1]);
        sw_got = '0;
        for (int i = 0; i < sq.size() && i < 8; i++) sw_got[cur_lsb ? i : 7 - i] = sq[i];
        check("slave_bits", sq.size(), 8);
        check("slave_rx", sw_got, cur_tx);
      end else if (ss_n !== ess || busy !== 1'b1) bad++;
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int d = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done || busy) d++;
    end
    check(tag, d, 0);
  endtask

  task automatic xfer_w(input logic [1:0] m, input logic l, input logic [15:0] tx);
    bit seen = 0;
    @(negedge clk);
    mode_w = m; lsb_w = l; tx_w = tx; sel_w = 2'd0; start_w = 1'b1;
    @(posedge clk);
    #1 start_w = 1'b0;
    for (int n = 1; n <= 80 && !seen; n++) begin
      @(negedge clk);
      if (done_w) begin
        seen = 1;
        check("w_latency", n, 35);
        check("w_rx_data", rx_w, tx);
        check("w_ss_at_done", ss_w, 3'b111);
        check("w_err", err_w, 1'b0);
        check("w_sclk_at_done", sclk_w, m[1]);
      end
    end
    check("w_done_seen", seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lb_tx [4];
    lb_tx[0] = 8'hE9; lb_tx[1] = 8'h99; lb_tx[2] = 8'hC9; lb_tx[3] = 8'hF0;
    reset = 1'b1; start = 1'b0; mode = '0; lsb_first = 1'b0; sel = '0; tx_data = '0;
    start_w = 1'b0; mode_w = '0; lsb_w = 1'b0; sel_w = '0; tx_w = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss_n", ss_n, 3'b111);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    loop_en = 1'b1;
    for (int m = 0; m < 4; m++) begin
      launch(2'(m), 1'b0, 2'd0, lb_tx[m], 8'h00, 1'b0);
      wait_done(0);
    end
    loop_en = 1'b0;

    launch(2'b00, 1'b1, 2'd0, 8'h01, 8'hFF, 1'b0);
    wait_done(0);
    check("lsb_first_bit", sq[0], 1'b1);

    launch(2'b00, 1'b0, 2'd1, 8'h6D, 8'hB2, 1'b0);
    wait_done(10);
    quiet(40, "ignored_start");

    launch(2'b01, 1'b0, 2'd3, 8'h4E, 8'h17, 1'b0);
    wait_done(0);

    launch(2'b10, 1'b0, 2'd2, 8'h5A, 8'hC3, 1'b1);
    wait_done(0);
    cur_mode = 2'b01; cur_lsb = 1'b1; cur_sel = 2'd0; cur_tx = 8'h3B; slv_word = 8'h96;
    mode = cur_mode; lsb_first = cur_lsb; sel = cur_sel; tx_data = cur_tx;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0);

    launch(2'b11, 1'b0, 2'd0, 8'hA5, 8'h3C, 1'b0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_sclk", sclk, 1'b0);
    check("abort_ss_n", ss_n, 3'b111);
    check("abort_busy", busy, 1'b0);
    check("abort_rx_data", rx_data, 8'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    quiet(50, "no_done_after_abort");

    for (int k = 0; k < 12; k++) begin
      launch(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom), 1'b0);
      wait_done(0);
    end

    for (int k = 0; k < 4; k++)
      xfer_w(2'(k), 1'($urandom_range(0, 1)), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
